// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter running on the 16x baud clock.
// Bytes are buffered in a small FIFO and shifted out LSB-first on UART_TX.
// Frames chain back-to-back with no idle gap while the FIFO has data.
module uart_sender #(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic       br_clk_16,
   input  logic       reset,
   input  logic [7:0] TX_DATA,
   input  logic       TX_EN,
   output logic       UART_TX,
   output logic       TX_STATUS,
   output logic       TX_FULL
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                         state_q, state_d;
   logic [3:0]                     bit_cnt_q, bit_cnt_d;
   logic [2:0]                     data_cnt_q, data_cnt_d;
   logic [7:0]                     shift_q, shift_d;
   logic                           tx_q, tx_d;
   logic                           status_q, status_d;
   logic                           full_q, full_d;
   logic [FIFO_DEPTH-1:0][7:0]     mem_q, mem_d;
   logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]               count_q, count_d;

   logic push;
   logic pop;
   logic fifo_empty;

   // Full check uses the pre-edge count, so a push while full is dropped even if a pop happens.
   assign push       = TX_EN && (count_q != CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   // FIFO storage, pointers and occupancy for the next edge
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = TX_DATA;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Frame sequencer: next state, line level, shifter and bit/cycle counters
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 4'd1;
      data_cnt_d = data_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d      = 1'b1;
            bit_cnt_d = 4'd0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_cnt_q == 4'd15) begin
               tx_d       = shift_q[0];
               shift_d    = {1'b0, shift_q[7:1]};
               data_cnt_d = 3'd0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (bit_cnt_q == 4'd15) begin
               if (data_cnt_q == 3'd7) begin
                  tx_d       = 1'b1;
                  data_cnt_d = 3'd0;
                  state_d    = STOP;
               end else begin
                  tx_d       = shift_q[0];
                  shift_d    = {1'b0, shift_q[7:1]};
                  data_cnt_d = data_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            // data_cnt doubles as the stop-bit index here
            if (bit_cnt_q == 4'd15) begin
               if (data_cnt_q == 3'(STOP_BITS - 1)) begin
                  data_cnt_d = 3'd0;
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     shift_d = mem_q[rd_ptr_q];
                     tx_d    = 1'b0;
                     state_d = START;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  data_cnt_d = data_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tx_d       = 1'b1;
            bit_cnt_d  = 4'd0;
            data_cnt_d = 3'd0;
         end
      endcase
   end

   // Status flags describe the state after this edge, so they are computed from the _d values
   always_comb begin
      full_d   = (count_d == CNT_W'(FIFO_DEPTH));
      status_d = (count_d == '0) && (state_d == IDLE);
   end

   // State registers; reset aborts any frame and drives the line high at once
   always_ff @(posedge br_clk_16 or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         data_cnt_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         status_q   <= 1'b1;
         full_q     <= 1'b0;
         mem_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         data_cnt_q <= data_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         status_q   <= status_d;
         full_q     <= full_d;
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   assign UART_TX   = tx_q;
   assign TX_STATUS = status_q;
   assign TX_FULL   = full_q;

endmodule
